// File: rtl/infix_to_rpn_if.sv
// Character handshake bundle between the host source, the
// infix-to-RPN converter and the RPN calculator input port.
interface infix_to_rpn_if;
  logic       IN_STB;
  logic [7:0] IN_CHAR;
  logic       IN_ACK;
  logic       OUT_STB;
  logic [7:0] OUT_CHAR;
  logic       OUT_ACK;
  logic       ERR;

  modport master (
    output IN_STB, IN_CHAR, OUT_ACK,
    input  IN_ACK, OUT_STB, OUT_CHAR, ERR
  );

  modport slave (
    input  IN_STB, IN_CHAR, OUT_ACK,
    output IN_ACK, OUT_STB, OUT_CHAR, ERR
  );
endinterface

// File: rtl/infix_to_rpn.sv
// Shunting-yard infix-to-postfix converter with an operator stack.
// Define I2R_ERR_CHAR_EN to emit '?' when entering the error state.
module infix_to_rpn #(
  parameter int STACK_DEPTH = 8,
  parameter int PTR_W       = 4
) (
  input logic           CLK,
  input logic           RST,
  infix_to_rpn_if.slave bus
);

  typedef enum logic [2:0] {
    S_IN,
    S_POP_OP,
    S_POP_PAREN,
    S_FLUSH,
    S_EQ,
    S_ERR,
    S_ERR_CH
  } state_t;

  localparam logic [7:0] C_ADD = 8'h2B;
  localparam logic [7:0] C_SUB = 8'h2D;
  localparam logic [7:0] C_MUL = 8'h2A;
  localparam logic [7:0] C_DIV = 8'h2F;
  localparam logic [7:0] C_LP  = 8'h28;
  localparam logic [7:0] C_RP  = 8'h29;
  localparam logic [7:0] C_EQ  = 8'h3D;
  localparam logic [7:0] C_SP  = 8'h20;
  localparam logic [7:0] C_QM  = 8'h3F;

  localparam logic [PTR_W-1:0] FULL = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

`ifdef I2R_ERR_CHAR_EN
  localparam state_t ERR_ENTRY = S_ERR_CH;
`else
  localparam state_t ERR_ENTRY = S_ERR;
`endif

  function automatic logic is_op(input logic [7:0] c);
    return c == C_ADD || c == C_SUB ||
           c == C_MUL || c == C_DIV;
  endfunction

  function automatic logic hi_prec(input logic [7:0] c);
    return c == C_MUL || c == C_DIV;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  state_t           state, nxt;
  logic [PTR_W-1:0] depth;
  logic [7:0]       stack [0:(1<<PTR_W)-1];
  logic [7:0]       pend;
  logic             out_stb;
  logic [7:0]       out_char;

  logic       accept, empty, full;
  logic [7:0] top, c;
  logic       load, push, pop, clear, pend_we;
  logic [7:0] load_char, push_char;

  assign c      = bus.IN_CHAR;
  assign empty  = depth == '0;
  assign full   = depth == FULL;
  assign top    = stack[depth - ONE];
  assign accept = bus.IN_STB && bus.IN_ACK;

  assign bus.IN_ACK   = !RST && !out_stb &&
                        (state == S_IN || state == S_ERR);
  assign bus.OUT_STB  = out_stb;
  assign bus.OUT_CHAR = out_char;
  assign bus.ERR      = !RST &&
                        (state == S_ERR || state == S_ERR_CH);

  always_comb begin
    nxt       = state;
    load      = 1'b0;
    load_char = 8'h00;
    push      = 1'b0;
    push_char = 8'h00;
    pop       = 1'b0;
    clear     = 1'b0;
    pend_we   = 1'b0;
    unique case (state)
      S_IN: if (accept) begin
        unique case (1'b1)
          is_digit(c): begin
            load      = 1'b1;
            load_char = c;
          end
          is_op(c): begin
            pend_we = 1'b1;
            nxt     = S_POP_OP;
          end
          c == C_LP: begin
            if (full) nxt = ERR_ENTRY;
            else begin
              push      = 1'b1;
              push_char = c;
            end
          end
          c == C_RP: nxt = S_POP_PAREN;
          c == C_EQ: nxt = S_FLUSH;
          c == C_SP: nxt = S_IN;
          default:   nxt = ERR_ENTRY;
        endcase
      end
      S_POP_OP: if (!out_stb) begin
        // Left-assoc: equal precedence on top pops first
        if (!empty && is_op(top) &&
            (hi_prec(top) || !hi_prec(pend))) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_char = top;
        end else if (full) begin
          nxt = ERR_ENTRY;
        end else begin
          push      = 1'b1;
          push_char = pend;
          nxt       = S_IN;
        end
      end
      S_POP_PAREN: if (!out_stb) begin
        if (empty) nxt = ERR_ENTRY;
        else if (top == C_LP) begin
          pop = 1'b1;
          nxt = S_IN;
        end else begin
          pop       = 1'b1;
          load      = 1'b1;
          load_char = top;
        end
      end
      S_FLUSH: if (!out_stb) begin
        if (empty) nxt = S_EQ;
        else if (top == C_LP) nxt = ERR_ENTRY;
        else begin
          pop       = 1'b1;
          load      = 1'b1;
          load_char = top;
        end
      end
      S_EQ: if (!out_stb) begin
        load      = 1'b1;
        load_char = C_EQ;
        nxt       = S_IN;
      end
      S_ERR: if (accept && c == C_EQ) begin
        clear = 1'b1;
        nxt   = S_IN;
      end
      S_ERR_CH: if (!out_stb) begin
        load      = 1'b1;
        load_char = C_QM;
        nxt       = S_ERR;
      end
      default: nxt = S_IN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IN;
      depth    <= '0;
      pend     <= 8'h00;
      out_stb  <= 1'b0;
      out_char <= 8'h00;
    end else begin
      state <= nxt;
      if (pend_we) pend <= c;
      if (load) begin
        out_stb  <= 1'b1;
        out_char <= load_char;
      end else if (out_stb && bus.OUT_ACK) begin
        out_stb <= 1'b0;
      end
      if (clear)     depth <= '0;
      else if (push) depth <= depth + ONE;
      else if (pop)  depth <= depth - ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) stack[depth] <= push_char;
  end

endmodule
